// File: rtl/amber48_dmem_arb.sv
// amber48_dmem_arb
// Round-robin arbiter/sequencer sharing the amber48_dmem primary request
// port between the core load/store unit (port 0) and the debug/loader
// master (port 1). Each grant is issued as a one-cycle mem_req_o pulse.
// A not-ready response re-issues the request. A bounded number of
// not-ready responses ends the access as a trapped completion.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   core_* / dbg_*           requester ports (req/we/addr/wdata in,
//                            done/rdata/trap out)
//   mem_*                    dmem request/response port
//   busy_o, owner_o          status: not idle, current owning port
//   timeout_o                one-cycle pulse on forced completion

package amber48_pkg;
  localparam int XLEN = 48;
endpackage

// state | meaning
// IDLE  | no transaction; sample both requests
// ISSUE | mem_req_o pulse with latched fields
// RESP  | evaluate registered ready: complete, retry or force completion
module amber48_dmem_arb
  import amber48_pkg::*;
#(
  parameter int RETRY_MAX = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            core_req_i,
  input  logic            core_we_i,
  input  logic [XLEN-1:0] core_addr_i,
  input  logic [XLEN-1:0] core_wdata_i,
  output logic            core_done_o,
  output logic [XLEN-1:0] core_rdata_o,
  output logic            core_trap_o,
  input  logic            dbg_req_i,
  input  logic            dbg_we_i,
  input  logic [XLEN-1:0] dbg_addr_i,
  input  logic [XLEN-1:0] dbg_wdata_i,
  output logic            dbg_done_o,
  output logic [XLEN-1:0] dbg_rdata_o,
  output logic            dbg_trap_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_ready_i,
  input  logic            mem_trap_i,
  output logic            busy_o,
  output logic            owner_o,
  output logic            timeout_o
);

  localparam int RW = (RETRY_MAX == 0) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [RW-1:0]   retry_q, retry_d;

  logic            done_c;
  logic            forced_c;
  logic            grant_c;
  logic            grant_port_c;
  logic            other_req_c;

  assign other_req_c = owner_q ? core_req_i : dbg_req_i;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    retry_d      = retry_q;
    done_c       = 1'b0;
    forced_c     = 1'b0;
    grant_c      = 1'b0;
    grant_port_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_req_i || dbg_req_i) begin
          grant_c = 1'b1;
          // On a tie the port that did not win last time goes next;
          // with a single requester, dbg_req_i alone names the winner.
          grant_port_c = (core_req_i && dbg_req_i) ? ~last_q : dbg_req_i;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        if (mem_ready_i) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else if (RETRY_MAX == 0 || retry_q < RMAX) begin
          // Saturate so an unlimited-retry configuration never wraps.
          if (retry_q != '1) retry_d = retry_q + 1'b1;
          state_d = ISSUE;
        end else begin
          done_c   = 1'b1;
          forced_c = 1'b1;
          state_d  = IDLE;
        end
        // Only the other port may be handed the memory on completion.
        if (done_c && other_req_c) begin
          grant_c      = 1'b1;
          grant_port_c = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_c) begin
      owner_d = grant_port_c;
      last_d  = grant_port_c;
      retry_d = '0;
      we_d    = grant_port_c ? dbg_we_i    : core_we_i;
      addr_d  = grant_port_c ? dbg_addr_i  : core_addr_i;
      wdata_d = grant_port_c ? dbg_wdata_i : core_wdata_i;
      state_d = ISSUE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      retry_q <= retry_d;
    end
  end

  logic [XLEN-1:0] rdata_c;
  logic            trap_c;

  assign rdata_c = forced_c ? '0 : mem_rdata_i;
  assign trap_c  = forced_c | mem_trap_i;

  assign mem_req_o   = (state_q == ISSUE);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign core_done_o  = done_c & ~owner_q;
  assign core_rdata_o = core_done_o ? rdata_c : '0;
  assign core_trap_o  = core_done_o & trap_c;
  assign dbg_done_o   = done_c & owner_q;
  assign dbg_rdata_o  = dbg_done_o ? rdata_c : '0;
  assign dbg_trap_o   = dbg_done_o & trap_c;

  assign busy_o    = (state_q != IDLE);
  assign owner_o   = owner_q;
  assign timeout_o = forced_c;

endmodule

// File: tb/tb_amber48_dmem_arb.sv
module tb_amber48_dmem_arb;

  localparam logic [47:0] UART_ADDR = 48'h0000_0000_0400;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // main DUT (RETRY_MAX = 16) with a behavioral dmem
  logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [47:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
  logic        c_done, c_trap, d_done, d_trap;
  logic [47:0] c_rdata, d_rdata;
  logic        m_req, m_we, m_ready, m_trap;
  logic [47:0] m_addr, m_wdata, m_rdata;
  logic        busy, owner, tmo;

  amber48_dmem_arb u_dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .core_req_i(c_req), .core_we_i(c_we), .core_addr_i(c_addr), .core_wdata_i(c_wdata),
    .core_done_o(c_done), .core_rdata_o(c_rdata), .core_trap_o(c_trap),
    .dbg_req_i(d_req), .dbg_we_i(d_we), .dbg_addr_i(d_addr), .dbg_wdata_i(d_wdata),
    .dbg_done_o(d_done), .dbg_rdata_o(d_rdata), .dbg_trap_o(d_trap),
    .mem_req_o(m_req), .mem_we_o(m_we), .mem_addr_o(m_addr), .mem_wdata_o(m_wdata),
    .mem_rdata_i(m_rdata), .mem_ready_i(m_ready), .mem_trap_i(m_trap),
    .busy_o(busy), .owner_o(owner), .timeout_o(tmo)
  );

  // second DUT (RETRY_MAX = 2), memory side driven directly
  logic        x_req = 0, x_ready = 0, x_trap_in = 0;
  logic [47:0] x_rdata_in = '0;
  logic        x_done, x_trap, xd_done, xd_trap;
  logic [47:0] x_rdata, xd_rdata;
  logic        x_mreq, x_mwe, x_busy, x_owner, x_tmo;
  logic [47:0] x_maddr, x_mwdata;

  amber48_dmem_arb #(.RETRY_MAX(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_ni),
    .core_req_i(x_req), .core_we_i(1'b0), .core_addr_i(48'h10), .core_wdata_i(48'h0),
    .core_done_o(x_done), .core_rdata_o(x_rdata), .core_trap_o(x_trap),
    .dbg_req_i(1'b0), .dbg_we_i(1'b0), .dbg_addr_i(48'h0), .dbg_wdata_i(48'h0),
    .dbg_done_o(xd_done), .dbg_rdata_o(xd_rdata), .dbg_trap_o(xd_trap),
    .mem_req_o(x_mreq), .mem_we_o(x_mwe), .mem_addr_o(x_maddr), .mem_wdata_o(x_mwdata),
    .mem_rdata_i(x_rdata_in), .mem_ready_i(x_ready), .mem_trap_i(x_trap_in),
    .busy_o(x_busy), .owner_o(x_owner), .timeout_o(x_tmo)
  );

  // behavioral dmem: registered ready one cycle after req, misaligned traps,
  // UART index declines while uart_rdy is low
  logic [47:0] ram [0:63];
  logic        uart_rdy = 1'b1;
  int          uart_cnt = 0;
  logic [7:0]  uart_data = '0;

  function automatic logic [47:0] ram_init(input int i);
    if (i == 3) return 48'h0000_1234_5678;
    return 48'hA5A5_0000_0000 | 48'(i);
  endfunction

  always @(posedge clk) begin
    m_ready <= 1'b0;
    m_trap  <= 1'b0;
    m_rdata <= '0;
    if (!rst_ni) begin
      for (int i = 0; i < 64; i++) ram[i] <= ram_init(i);
    end else if (m_req) begin
      if (m_addr[2:0] != 3'd0) begin
        m_ready <= 1'b1;
        m_trap  <= 1'b1;
      end else if (m_addr == UART_ADDR) begin
        if (uart_rdy) begin
          m_ready <= 1'b1;
          if (m_we) begin
            uart_cnt  <= uart_cnt + 1;
            uart_data <= m_wdata[7:0];
          end
        end
      end else begin
        m_ready <= 1'b1;
        if (m_we) ram[m_addr[8:3]] <= m_wdata;
        else m_rdata <= ram[m_addr[8:3]];
      end
    end
  end

  int consec_viol = 0;
  logic m_req_prev = 1'b0, x_mreq_prev = 1'b0;
  always @(posedge clk) begin
    m_req_prev  <= m_req;
    x_mreq_prev <= x_mreq;
    if ((m_req && m_req_prev) || (x_mreq && x_mreq_prev)) consec_viol <= consec_viol + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", m_req); end
    n_checks++; if (owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %b want 0", owner); end
    n_checks++; if ({c_done, d_done, tmo} !== 3'b000) begin n_fail++; $display("FAIL reset_done_tmo: got %b want 000", {c_done, d_done, tmo}); end
    n_checks++; if ({m_addr, m_wdata, m_we} !== 97'd0) begin n_fail++; $display("FAIL reset_mem_fields: got %h/%h/%b want 0", m_addr, m_wdata, m_we); end
    rst_ni = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_core_read();
    c_we = 0; c_addr = 48'd24; c_req = 1;
    tick();
    n_checks++; if (m_req !== 1'b1 || m_addr !== 48'd24) begin n_fail++; $display("FAIL read_issue: got req=%b addr=%h want 1/18", m_req, m_addr); end
    n_checks++; if (c_done !== 1'b0) begin n_fail++; $display("FAIL read_early_done: got %b want 0", c_done); end
    tick();
    n_checks++; if (c_done !== 1'b1 || c_trap !== 1'b0) begin n_fail++; $display("FAIL read_done: got done=%b trap=%b want 1/0", c_done, c_trap); end
    n_checks++; if (c_rdata !== 48'h0000_1234_5678) begin n_fail++; $display("FAIL read_rdata: got %h want 000012345678", c_rdata); end
    n_checks++; if (d_done !== 1'b0 || m_req !== 1'b0) begin n_fail++; $display("FAIL read_other: got dbg_done=%b mem_req=%b want 0/0", d_done, m_req); end
    c_req = 0;
    tick();
    n_checks++; if (busy !== 1'b0 || c_done !== 1'b0) begin n_fail++; $display("FAIL read_idle: got busy=%b done=%b want 0/0", busy, c_done); end
  endtask

  task automatic test_contention();
    int cd = 0, dd = 0, last_cyc = 0, k = 0;
    logic exp_p = 1'b0;
    logic [47:0] exp_d, got_d;
    rst_ni = 0; tick(); rst_ni = 1;
    c_we = 0; d_we = 0; c_addr = 48'd80; d_addr = 48'd160;
    c_req = 1; d_req = 1;
    for (int cyc = 1; cyc <= 30 && (cd < 4 || dd < 4); cyc++) begin
      tick();
      if (c_done || d_done) begin
        n_checks++; if ({c_done, d_done} !== (exp_p ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL cont_order%0d: got core=%b dbg=%b want port %0d", k, c_done, d_done, exp_p); end
        n_checks++; if (cyc - last_cyc != 2) begin n_fail++; $display("FAIL cont_gap%0d: got %0d cycles want 2", k, cyc - last_cyc); end
        exp_d = exp_p ? ram_init(20 + dd) : ram_init(10 + cd);
        got_d = exp_p ? d_rdata : c_rdata;
        n_checks++; if (got_d !== exp_d) begin n_fail++; $display("FAIL cont_rdata%0d: got %h want %h", k, got_d, exp_d); end
        if (c_done) begin cd++; c_addr = 48'(8 * (10 + cd)); if (cd == 4) c_req = 0; end
        if (d_done) begin dd++; d_addr = 48'(8 * (20 + dd)); if (dd == 4) d_req = 0; end
        last_cyc = cyc; k++; exp_p = ~exp_p;
      end
    end
    c_req = 0; d_req = 0;
    n_checks++; if (cd != 4 || dd != 4) begin n_fail++; $display("FAIL cont_counts: got core=%0d dbg=%0d want 4/4", cd, dd); end
    tick();
  endtask

  task automatic test_uart_stall();
    int pulses = 0, dones = 0, done_cyc = -1, v0;
    logic tmo_seen = 0, trap_at_done = 0;
    v0 = uart_cnt;
    uart_rdy = 0;
    d_we = 1; d_addr = UART_ADDR; d_wdata = 48'h41; d_req = 1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (m_req) begin pulses++; if (pulses == 4) uart_rdy = 1; end
      if (tmo) tmo_seen = 1;
      if (d_done) begin dones++; done_cyc = cyc; trap_at_done = d_trap; d_req = 0; end
    end
    uart_rdy = 1; d_we = 0;
    n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL uart_pulses: got %0d want 4", pulses); end
    n_checks++; if (dones != 1 || done_cyc != 8) begin n_fail++; $display("FAIL uart_done: got %0d dones at %0d want 1 at 8", dones, done_cyc); end
    n_checks++; if (uart_cnt - v0 != 1 || uart_data !== 8'h41) begin n_fail++; $display("FAIL uart_valid: got %0d writes data %h want 1/41", uart_cnt - v0, uart_data); end
    n_checks++; if (tmo_seen !== 1'b0 || trap_at_done !== 1'b0) begin n_fail++; $display("FAIL uart_tmo_trap: got tmo=%b trap=%b want 0/0", tmo_seen, trap_at_done); end
  endtask

  task automatic test_misaligned();
    c_we = 1; c_addr = 48'd5; c_wdata = 48'hFFFF_FFFF_FFFF; c_req = 1;
    tick();
    n_checks++; if (m_req !== 1'b1 || m_we !== 1'b1) begin n_fail++; $display("FAIL mis_issue: got req=%b we=%b want 1/1", m_req, m_we); end
    tick();
    n_checks++; if (c_done !== 1'b1 || c_trap !== 1'b1 || c_rdata !== 48'd0) begin n_fail++; $display("FAIL mis_done: got done=%b trap=%b rdata=%h want 1/1/0", c_done, c_trap, c_rdata); end
    c_req = 0; c_we = 0;
    tick();
    n_checks++; if (ram[0] !== ram_init(0)) begin n_fail++; $display("FAIL mis_ram: got %h want %h", ram[0], ram_init(0)); end
  endtask

  task automatic test_timeout();
    int pulses = 0, done_cyc = -1, tmo_cnt = 0;
    logic trap_d = 0, tmo_d = 0;
    logic [47:0] rdata_d = '1;
    x_ready = 0; x_rdata_in = 48'hDEAD_BEEF_0000; x_trap_in = 0; x_req = 1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (x_mreq) pulses++;
      if (x_tmo) tmo_cnt++;
      if (x_done) begin done_cyc = cyc; trap_d = x_trap; rdata_d = x_rdata; tmo_d = x_tmo; x_req = 0; end
    end
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL tmo_pulses: got %0d want 3", pulses); end
    n_checks++; if (done_cyc != 6) begin n_fail++; $display("FAIL tmo_done_cycle: got %0d want 6", done_cyc); end
    n_checks++; if (trap_d !== 1'b1 || rdata_d !== 48'd0 || tmo_d !== 1'b1) begin n_fail++; $display("FAIL tmo_done: got trap=%b rdata=%h tmo=%b want 1/0/1", trap_d, rdata_d, tmo_d); end
    n_checks++; if (tmo_cnt != 1) begin n_fail++; $display("FAIL tmo_count: got %0d want 1", tmo_cnt); end
    x_ready = 1; x_rdata_in = 48'h55; x_req = 1;
    tick(); tick();
    n_checks++; if (x_done !== 1'b1 || x_rdata !== 48'h55 || x_trap !== 1'b0 || x_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_next: got done=%b rdata=%h trap=%b tmo=%b want 1/55/0/0", x_done, x_rdata, x_trap, x_tmo); end
    x_req = 0; x_ready = 0;
    tick();
  endtask

  task automatic test_reset_midop();
    uart_rdy = 0; c_we = 0; c_addr = UART_ADDR; c_req = 1;
    tick(); tick();
    n_checks++; if (busy !== 1'b1 || c_done !== 1'b0) begin n_fail++; $display("FAIL midop_resp: got busy=%b done=%b want 1/0", busy, c_done); end
    rst_ni = 0;
    #1;
    n_checks++; if ({busy, m_req, c_done, d_done, tmo, owner} !== 6'd0) begin n_fail++; $display("FAIL midop_outputs: got %b want 000000", {busy, m_req, c_done, d_done, tmo, owner}); end
    n_checks++; if (m_addr !== 48'd0) begin n_fail++; $display("FAIL midop_addr: got %h want 0", m_addr); end
    c_req = 0;
    tick();
    rst_ni = 1; uart_rdy = 1;
    c_addr = 48'd24; d_addr = 48'd32; d_we = 0; c_req = 1; d_req = 1;
    tick();
    n_checks++; if (m_req !== 1'b1 || owner !== 1'b0 || m_addr !== 48'd24) begin n_fail++; $display("FAIL midop_first_grant: got req=%b owner=%b addr=%h want 1/0/18", m_req, owner, m_addr); end
    tick();
    n_checks++; if (c_done !== 1'b1 || c_rdata !== ram_init(3) || d_done !== 1'b0) begin n_fail++; $display("FAIL midop_core_done: got done=%b rdata=%h dbg=%b", c_done, c_rdata, d_done); end
    c_req = 0;
    tick(); tick();
    n_checks++; if (d_done !== 1'b1 || d_rdata !== ram_init(4)) begin n_fail++; $display("FAIL midop_dbg_done: got done=%b rdata=%h want 1/%h", d_done, d_rdata, ram_init(4)); end
    d_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_contention();
    test_uart_stall();
    test_misaligned();
    test_timeout();
    test_reset_midop();
    n_checks++; if (consec_viol != 0) begin n_fail++; $display("FAIL mem_req_consecutive: got %0d violations want 0", consec_viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
